dmem_bus_bridge: RTL and testbench
==================================

# dmem_bus_bridge

Converts the CPU core's single-cycle MEM-stage data-memory interface (memwriteM, memtoregM, aluoutM, writedataM, mem_opM, readdataM) into a split-handshake data bus (req / addr_ok / data_ok). It sits directly downstream of the core's MEM stage and stalls the pipeline while a transaction is outstanding. It also performs byte-lane steering for stores, byte-strobe generation and load sign/zero extension.

## Interface
Parameters: none.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- memwriteM  in  1  store request from MEM stage (already masked on exception commit)
- memtoregM  in  1  load request from MEM stage
- excM  in  1  MEM-stage exception; suppresses issuing a new access
- aluoutM  in  32  effective byte address
- writedataM  in  32  store data, right-aligned
- mem_opM  in  3  size/sign: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; 101–111 treated as word
- readdataM  out  32  extended load result to core
- stallM  out  1  freeze IF..MEM stages
- data_req  out  1  bus request valid
- data_wr  out  1  1 = write, 0 = read
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  byte address, equals latched aluoutM
- data_wstrb  out  4  byte enables for writes; 0000 on reads
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  slave accepted request
- data_data_ok  in  1  write done / read data valid
- data_rdata  in  32  read word, natural lanes

## Operation
- An access is `(memwriteM | memtoregM) & ~excM`. If both memwriteM and memtoregM are high, the access is a write.
- State machine: IDLE, REQ, WAIT, DONE.
  - IDLE:
    - If an access is present: latch addr, wr, size, wstrb, wdata, mem_opM and addr[1:0]; go to REQ.
    - Otherwise stay in IDLE.
  - REQ: data_req = 1 from the latched registers.
    - addr_ok & data_ok → DONE.
    - addr_ok only → WAIT.
    - Neither → stay in REQ.
  - WAIT: data_req = 0.
    - data_ok → DONE.
    - Otherwise stay in WAIT.
  - DONE: always → IDLE. The core advances at the end of this cycle.
- On data_ok for a read, latch data_rdata into rword.
- stallM = (IDLE & access) | REQ | WAIT. stallM is 0 in DONE and in IDLE with no access.
- Store steering, with o = addr[1:0]:
  - Byte: wstrb = 0001 << o; wdata = {4{wd[7:0]}}.
  - Half: wstrb = 0011 << o; wdata = {2{wd[15:0]}}.
  - Word: wstrb = 1111; wdata = wd.
- Load extract, computed from rword and the latched op/offset:
  - Byte: take rword[8o+7:8o], sign- or zero-extend per op.
  - Half: take rword[16·o[1]+15 : 16·o[1]], sign- or zero-extend per op.
  - Word: rword.
- readdataM holds the extracted value from DONE until the next read completes. It is not updated by writes.
- Alignment is not checked here; AdEL/AdES are caught upstream via excM. A misaligned half (o = 1 or 3) uses o[1] only.

## Timing
- Reset values: state IDLE; data_req 0, data_wr 0, data_size 0, data_addr 0, data_wstrb 0, data_wdata 0, readdataM 0, rword 0. stallM is 0 while no access is present.
- Minimum access, with addr_ok and data_ok both arriving in the first REQ cycle:
  - Cycle 0: IDLE, stallM = 1.
  - Cycle 1: REQ, stallM = 1.
  - Cycle 2: DONE, stallM = 0, readdataM valid.
  - Cycle 3: IDLE, ready to accept a new access.
- Each extra cycle waiting for addr_ok or data_ok adds one stall cycle.
- Back-to-back accesses: the second access is seen in IDLE on the cycle after DONE. There is no overlap; at most one transaction is outstanding.
- Bus outputs are registered and are held constant throughout REQ until addr_ok.
- excM is sampled only in IDLE. It is ignored once the block is in REQ, WAIT or DONE.
- data_ok arriving in IDLE or DONE (spurious) is ignored; rword is unchanged.
- Reset mid-transaction: return to IDLE immediately (asynchronous) and drop data_req. The bus slave shares rst, so nothing is left in flight.

## Test plan
- Load word, slave returns addr_ok and data_ok in REQ with data_rdata = 0x8899AABB:
  - stallM high for exactly 2 cycles.
  - readdataM = 0x8899AABB in DONE.
- Load byte signed at address 0x…02 with data_rdata = 0x1280FF34 → readdataM = 0xFFFFFF80.
- Load half unsigned at address 0x…02 with data_rdata = 0x80120000 → readdataM = 0x00008012.
- Store byte at address 0x…03 with writedataM = 0x000000A5:
  - data_wr = 1, data_wstrb = 1000, data_wdata = 0xA5A5A5A5, data_size = 0.
- Store half at address 0x…02 with writedataM = 0x0000BEEF:
  - data_wstrb = 1100, data_wdata = 0xBEEFBEEF, data_size = 1.
- Handshake and control corner cases:
  - addr_ok delayed 3 cycles, then data_ok 2 cycles later: data_req held and data_addr stable throughout REQ; stallM high for 6 cycles.
  - excM = 1 together with memwriteM: no data_req, stallM = 0.
  - rst asserted while in WAIT: data_req = 0 and state IDLE in the same cycle.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns the MEM-stage single-cycle data-memory port into a
// req / addr_ok / data_ok split-handshake bus. The bridge stalls the pipeline
// while a transaction is outstanding. It steers store data onto byte lanes,
// generates byte strobes and sign/zero-extends load results.
module dmem_bus_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwriteM,
  input  logic        memtoregM,
  input  logic        excM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [2:0]  mem_opM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q;
  logic        req_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [2:0]  op_q;
  // Load result is extracted as the bus word arrives and stored here.
  // It holds until the next read completes.
  logic [31:0] rdata_q;

  logic        access;
  logic [1:0]  size_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] load_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A store wins when both store and load are asserted.
  assign access = (memwriteM | memtoregM) & ~excM;

  // Size, lane strobes and lane-replicated data for the access now presented.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    size_d  = 2'd2;
    wstrb_d = 4'b1111;
    wdata_d = writedataM;
    case (mem_opM)
      3'b001, 3'b010: begin
        size_d  = 2'd0;
        wstrb_d = 4'b0001 << aluoutM[1:0];
        wdata_d = {4{writedataM[7:0]}};
      end
      3'b011, 3'b100: begin
        size_d  = 2'd1;
        wstrb_d = 4'b0011 << aluoutM[1:0];
        wdata_d = {2{writedataM[15:0]}};
      end
      default: ;
    endcase
    if (!memwriteM) wstrb_d = 4'b0000;
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  // A misaligned half uses only the upper offset bit.
  always_comb begin
    byte_sel = data_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = data_rdata[{addr_q[1], 4'b0000} +: 16];
    case (op_q)
      3'b001:  load_d = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_d = {24'b0, byte_sel};
      3'b011:  load_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_d = {16'b0, half_sel};
      default: load_d = data_rdata;
    endcase
  end

  // Transaction FSM with registered bus outputs and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'b0;
      wstrb_q <= 4'b0;
      wdata_q <= 32'b0;
      op_q    <= 3'b0;
      rdata_q <= 32'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            wr_q    <= memwriteM;
            size_q  <= size_d;
            addr_q  <= aluoutM;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            op_q    <= mem_opM;
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            req_q <= 1'b0;
            if (data_data_ok) begin
              state_q <= DONE;
              if (!wr_q) rdata_q <= load_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            state_q <= DONE;
            if (!wr_q) rdata_q <= load_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stallM     = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == WAIT);
  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;
  assign readdataM  = rdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Testbench for dmem_bus_bridge. The stimulus pushes the expected bus request,
// stall length and load result into a queue. A negedge monitor compares them
// against the DUT. A delay-programmable slave answers the bus and injects
// spurious data_ok pulses while no transaction is outstanding.
module tb_dmem_bus_bridge;

  logic        clk, rst;
  logic        memwriteM, memtoregM, excM;
  logic [31:0] aluoutM, writedataM;
  logic [2:0]  mem_opM;
  logic [31:0] readdataM;
  logic        stallM, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  dmem_bus_bridge dut (
    .clk(clk), .rst(rst),
    .memwriteM(memwriteM), .memtoregM(memtoregM), .excM(excM),
    .aluoutM(aluoutM), .writedataM(writedataM), .mem_opM(mem_opM),
    .readdataM(readdataM), .stallM(stallM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
  } txn_t;

  typedef struct {
    int          d1;
    int          d2;
    logic [31:0] rdata;
  } sl_t;

  txn_t        txq[$];
  sl_t         sl_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: load extraction by shifting and masking the word.
  function automatic logic [31:0] model_load(logic [2:0] op, logic [31:0] addr, logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * addr[1:0])) & 32'hFF;
    h = (w >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic txn_t make_txn(logic wr, logic rd, logic [31:0] addr, logic [31:0] wd,
                                    logic [31:0] rdata, logic [2:0] op, int d1, int d2);
    txn_t t;
    int   nbytes;
    nbytes  = (op == 3'd1 || op == 3'd2) ? 1 : (op == 3'd3 || op == 3'd4) ? 2 : 4;
    t.wr    = wr;
    t.rd    = rd & ~wr;
    t.size  = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
    t.addr  = addr;
    t.wstrb = wr ? 4'(((1 << nbytes) - 1) << ((nbytes == 4) ? 0 : addr[1:0])) : 4'b0;
    t.wdata = (nbytes == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (nbytes == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    t.rdata = model_load(op, addr, rdata);
    t.stall = 2 + d1 + d2;
    return t;
  endfunction

  // Present one MEM-stage access. Return in the first cycle after it retires.
  task automatic issue(input logic wr, input logic rd, input logic exc, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input logic [2:0] op,
                       input int d1, input int d2);
    sl_t s;
    int  n;
    memwriteM = wr; memtoregM = rd; excM = exc;
    aluoutM = addr; writedataM = wd; mem_opM = op;
    if ((wr | rd) && !exc) begin
      txq.push_back(make_txn(wr, rd, addr, wd, rdata, op, d1, d2));
      s.d1 = d1; s.d2 = d2; s.rdata = rdata;
      sl_q.push_back(s);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (stallM && n < 100);
      if (stallM) begin
        n_cmp++; n_fail++;
        $display("FAIL access_timeout: stallM still %b after %0d cycles, required 0", stallM, n);
      end
    end else begin
      @(negedge clk);
      check("exc_stall", {31'b0, stallM}, 32'd0);
      check("exc_req", {31'b0, data_req}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    memwriteM = 1'b0; memtoregM = 1'b0; excM = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Bus slave: grants addr_ok after d1 extra REQ cycles, data_ok d2 cycles later.
  initial begin
    int  phase = 0;
    int  cnt = 0;
    sl_t s;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'b0;
    forever begin
      @(posedge clk); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      if (rst) begin
        phase = 0;
      end else begin
        if (phase == 0 && data_req && sl_q.size() > 0) begin
          s = sl_q.pop_front(); phase = 1; cnt = s.d1;
        end
        if (phase == 1) begin
          if (cnt == 0) begin
            data_addr_ok = 1'b1;
            if (s.d2 == 0) begin
              data_data_ok = 1'b1; data_rdata = s.rdata; phase = 0;
            end else begin
              phase = 2; cnt = s.d2 - 1;
            end
          end else cnt--;
        end else if (phase == 2) begin
          if (cnt == 0) begin
            data_data_ok = 1'b1; data_rdata = s.rdata; phase = 0;
          end else cnt--;
        end else if (!data_req && $urandom_range(0, 3) == 0) begin
          data_data_ok = 1'b1;
        end
      end
    end
  end

  // Monitor: bus fields while requesting, stall length and load result at retirement.
  initial begin
    int   run = 0;
    logic accepted = 1'b0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; accepted = 1'b0;
      end else begin
        if (data_req) begin
          if (txq.size() == 0 || accepted) begin
            check("unexpected_req", {31'b0, data_req}, 32'd0);
          end else begin
            t = txq[0];
            check("bus_wr", {31'b0, data_wr}, {31'b0, t.wr});
            check("bus_size", {30'b0, data_size}, {30'b0, t.size});
            check("bus_addr", data_addr, t.addr);
            check("bus_wstrb", {28'b0, data_wstrb}, {28'b0, t.wstrb});
            if (t.wr) check("bus_wdata", data_wdata, t.wdata);
            if (data_addr_ok) accepted = 1'b1;
          end
        end
        if (stallM) begin
          run++;
        end else if (run > 0) begin
          if (txq.size() == 0) begin
            check("done_without_txn", run, 32'd0);
          end else begin
            t = txq.pop_front();
            check("stall_cycles", run, t.stall);
            if (t.rd) begin
              check("readdata", readdataM, t.rdata);
              last_rd = t.rdata;
            end else begin
              check("readdata_hold", readdataM, last_rd);
            end
          end
          run = 0; accepted = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    memwriteM = 1'b0; memtoregM = 1'b0; excM = 1'b0;
    aluoutM = 32'b0; writedataM = 32'b0; mem_opM = 3'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_req", {31'b0, data_req}, 32'd0);
    check("rst_wr", {31'b0, data_wr}, 32'd0);
    check("rst_size", {30'b0, data_size}, 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_wstrb", {28'b0, data_wstrb}, 32'd0);
    check("rst_wdata", data_wdata, 32'd0);
    check("rst_readdata", readdataM, 32'd0);
    check("rst_stall", {31'b0, stallM}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Directed cases.
    issue(0, 1, 0, 32'h0000_1000, 32'h0, 32'h8899AABB, 3'd0, 0, 0);
    issue(0, 1, 0, 32'h0000_2002, 32'h0, 32'h1280FF34, 3'd1, 0, 0);
    issue(0, 1, 0, 32'h0000_3002, 32'h0, 32'h80120000, 3'd4, 0, 0);
    issue(1, 0, 0, 32'h0000_4003, 32'h0000_00A5, 32'h0, 3'd2, 0, 0);
    issue(1, 0, 0, 32'h0000_5002, 32'h0000_BEEF, 32'h0, 3'd3, 0, 0);
    // addr_ok three cycles after the access appears, data_ok two cycles after that.
    issue(0, 1, 0, 32'h0000_6004, 32'h0, 32'hCAFE0123, 3'd0, 2, 2);
    issue(1, 0, 1, 32'h0000_7000, 32'h1234_5678, 32'h0, 3'd0, 0, 0);
    issue(1, 1, 0, 32'h0000_8001, 32'h0000_0077, 32'h0, 3'd1, 1, 1);
    idle(2);

    // Reset while the transaction waits for data_ok.
    begin
      sl_t s;
      memtoregM = 1'b1; excM = 1'b0; mem_opM = 3'd0; aluoutM = 32'h0000_9000;
      txq.push_back(make_txn(0, 1, 32'h0000_9000, 32'h0, 32'h5555AAAA, 3'd0, 0, 40));
      s.d1 = 0; s.d2 = 40; s.rdata = 32'h5555AAAA;
      sl_q.push_back(s);
      repeat (3) begin @(posedge clk); #1; end
      #2;
      rst = 1'b1;
      memtoregM = 1'b0;
      #1;
      check("rst_wait_req", {31'b0, data_req}, 32'd0);
      check("rst_wait_stall", {31'b0, stallM}, 32'd0);
      check("rst_wait_readdata", readdataM, 32'd0);
      txq.delete(); sl_q.delete(); last_rd = 32'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      idle(1);
    end

    // Randomized traffic.
    for (int k = 0; k < 250; k++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      int          kind;
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if (op == 3'd3 || op == 3'd4) addr[0] = 1'b0;
      else if (op != 3'd1 && op != 3'd2) addr[1:0] = 2'b00;
      kind = $urandom_range(0, 9);
      if (kind < 4)
        issue(0, 1, 0, addr, $urandom, $urandom, op, $urandom_range(0, 3), $urandom_range(0, 3));
      else if (kind < 8)
        issue(1, 0, 0, addr, $urandom, $urandom, op, $urandom_range(0, 3), $urandom_range(0, 3));
      else if (kind == 8)
        issue(1, 1, 0, addr, $urandom, $urandom, op, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        issue(1'($urandom_range(0, 1)), 1, 1, addr, $urandom, $urandom, op, 0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    check("txq_drained", txq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
